// File: rtl/opl3_pkg.sv
// opl3_pkg: shared constants and types for the OPL3 mixing path.
//   SAMPLE_WIDTH        width of one signed stereo sample at the DAC side
//   NUM_CHANNELS_TOTAL  channel strobes per sample period (2 banks x 9)
//   mixer_state_t       sequencer FSM states
//   imax                constant-friendly integer max for width math
package opl3_pkg;

    localparam int SAMPLE_WIDTH       = 16;
    localparam int NUM_CHANNELS_TOTAL = 18;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        SAT   = 2'd2
    } mixer_state_t;

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sat_clamp.sv
// sat_clamp: combinational signed saturation from IN_WIDTH down to OUT_WIDTH.
//   din   in   IN_WIDTH   signed value (IN_WIDTH must exceed OUT_WIDTH)
//   dout  out  OUT_WIDTH  din clamped to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1]
module sat_clamp #(
    parameter int IN_WIDTH  = 22,
    parameter int OUT_WIDTH = 16
) (
    input  logic signed [IN_WIDTH-1:0]  din,
    output logic signed [OUT_WIDTH-1:0] dout
);

    // Output range limits expressed at the input width so the compare is signed.
    localparam logic signed [IN_WIDTH-1:0] MAX_IN =
        {{(IN_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [IN_WIDTH-1:0] MIN_IN =
        {{(IN_WIDTH-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

    always_comb begin
        dout = din[OUT_WIDTH-1:0];
        if (din > MAX_IN)
            dout = MAX_IN[OUT_WIDTH-1:0];
        else if (din < MIN_IN)
            dout = MIN_IN[OUT_WIDTH-1:0];
    end

endmodule

// File: rtl/channel_mixer_sequencer.sv
// channel_mixer_sequencer: gathers one sample period of time-multiplexed OPL3
// channel outputs into left/right sums, saturates them and presents one stereo
// sample per period.
//   clk, reset      clock; synchronous active-high reset
//   sample_clk_en   pulse starting a sample period
//   ch_valid        strobe qualifying ch_out / ch_l_en / ch_r_en
//   ch_out          signed channel output
//   ch_l_en/ch_r_en route the strobe into the left / right sum
//   channel_valid   one-cycle pulse, new channel_l/channel_r
//   channel_l/r     saturated mix, held between pulses
//   busy            FSM not idle
//   overrun_err     sticky: period restarted before all strobes arrived
//   drop_err        sticky: strobe arrived outside an accumulation window
module channel_mixer_sequencer
    import opl3_pkg::*;
#(
    parameter int NUM_CHANNELS = NUM_CHANNELS_TOTAL,
    parameter int CH_WIDTH     = 16
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           sample_clk_en,
    input  logic                           ch_valid,
    input  logic signed [CH_WIDTH-1:0]     ch_out,
    input  logic                           ch_l_en,
    input  logic                           ch_r_en,
    output logic                           channel_valid,
    output logic signed [SAMPLE_WIDTH-1:0] channel_l,
    output logic signed [SAMPLE_WIDTH-1:0] channel_r,
    output logic                           busy,
    output logic                           overrun_err,
    output logic                           drop_err
);

    // Wide enough that NUM_CHANNELS full-scale inputs can never wrap.
    localparam int ACC_W = imax(CH_WIDTH, SAMPLE_WIDTH) + $clog2(NUM_CHANNELS) + 1;
    localparam int CNT_W = $clog2(NUM_CHANNELS + 1);

    mixer_state_t                   state, state_n;
    logic signed [ACC_W-1:0]        acc_l, acc_r, acc_l_n, acc_r_n;
    logic signed [ACC_W-1:0]        ch_ext, add_l, add_r;
    logic [CNT_W-1:0]               cnt, cnt_n;
    logic                           load_out, set_ovr, set_drop;
    logic signed [SAMPLE_WIDTH-1:0] sat_l, sat_r;

    assign ch_ext = {{(ACC_W-CH_WIDTH){ch_out[CH_WIDTH-1]}}, ch_out};
    assign add_l  = (ch_valid && ch_l_en) ? ch_ext : '0;
    assign add_r  = (ch_valid && ch_r_en) ? ch_ext : '0;
    assign busy   = (state != IDLE);

    sat_clamp #(.IN_WIDTH(ACC_W), .OUT_WIDTH(SAMPLE_WIDTH)) u_sat_l (.din(acc_l), .dout(sat_l));
    sat_clamp #(.IN_WIDTH(ACC_W), .OUT_WIDTH(SAMPLE_WIDTH)) u_sat_r (.din(acc_r), .dout(sat_r));

    always_comb begin
        state_n  = state;
        acc_l_n  = acc_l;
        acc_r_n  = acc_r;
        cnt_n    = cnt;
        load_out = 1'b0;
        set_ovr  = 1'b0;
        set_drop = 1'b0;
        case (state)
            IDLE, SAT: begin
                // SAT publishes the finished sums; a coincident period start
                // is then handled exactly like one arriving in IDLE.
                load_out = (state == SAT);
                if (sample_clk_en) begin
                    // A strobe sharing the start cycle seeds the new period.
                    state_n = (ch_valid && (NUM_CHANNELS == 1)) ? SAT : ACCUM;
                    acc_l_n = add_l;
                    acc_r_n = add_r;
                    cnt_n   = {{(CNT_W-1){1'b0}}, ch_valid};
                end else begin
                    state_n  = IDLE;
                    set_drop = ch_valid;
                end
            end
            ACCUM: begin
                if (sample_clk_en) begin
                    // Short period: flush partial sums; the new period is lost.
                    state_n = SAT;
                    set_ovr = 1'b1;
                end else if (ch_valid) begin
                    acc_l_n = acc_l + add_l;
                    acc_r_n = acc_r + add_r;
                    cnt_n   = cnt + 1'b1;
                    if (cnt == CNT_W'(NUM_CHANNELS - 1))
                        state_n = SAT;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            acc_l         <= '0;
            acc_r         <= '0;
            cnt           <= '0;
            channel_valid <= 1'b0;
            channel_l     <= '0;
            channel_r     <= '0;
            overrun_err   <= 1'b0;
            drop_err      <= 1'b0;
        end else begin
            state         <= state_n;
            acc_l         <= acc_l_n;
            acc_r         <= acc_r_n;
            cnt           <= cnt_n;
            channel_valid <= load_out;
            if (load_out) begin
                channel_l <= sat_l;
                channel_r <= sat_r;
            end
            overrun_err   <= overrun_err | set_ovr;
            drop_err      <= drop_err | set_drop;
        end
    end

endmodule
